wb_cpu_bus_master: RTL and testbench



---
 rtl/wb_cpu_bus_master.sv | 220 ++++++++++++++++++++++
 tb/tb_wb_cpu_bus_master.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cpu_bus_master.sv
// Wishbone B4 classic master for the CPU load/store unit: lane steering,
// read extension, alignment check, ERR_I and watchdog with error cause.
// Ports: CLK_I/RST_I; CPU side I_en/I_op/I_addr/I_data in and
// O_data/O_busy/O_done/O_err/O_err_cause out; Wishbone ACK_I/ERR_I/DAT_I in
// and registered ADR_O/DAT_O/SEL_O/CYC_O/STB_O/WE_O out.
module wb_cpu_bus_master #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit ALIGN_CHECK    = 1'b1
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              I_en,
  input  logic [3:0]        I_op,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [31:0]       I_data,
  output logic [31:0]       O_data,
  output logic              O_busy,
  output logic              O_done,
  output logic              O_err,
  output logic [1:0]        O_err_cause,
  input  logic              ACK_I,
  input  logic              ERR_I,
  input  logic [31:0]       DAT_I,
  output logic [ADDR_W-1:0] ADR_O,
  output logic [31:0]       DAT_O,
  output logic [3:0]        SEL_O,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O
);

  // Bit 3 of the opcode marks a write.
  localparam logic [3:0] BUSOP_READB  = 4'h0;
  localparam logic [3:0] BUSOP_READBU = 4'h1;
  localparam logic [3:0] BUSOP_READH  = 4'h2;
  localparam logic [3:0] BUSOP_READHU = 4'h3;
  localparam logic [3:0] BUSOP_READW  = 4'h4;
  localparam logic [3:0] BUSOP_READT  = 4'h5;
  localparam logic [3:0] BUSOP_WRITEB = 4'h8;
  localparam logic [3:0] BUSOP_WRITEH = 4'hA;
  localparam logic [3:0] BUSOP_WRITEW = 4'hC;
  localparam logic [3:0] BUSOP_WRITET = 4'hD;

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_nxt;
  logic [3:0]        op_q, op_d;
  logic [1:0]        lo_q, lo_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic [1:0]        cause_q, cause_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic [3:0]        sel_q, sel_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;

  logic              is_b, is_h, is_t, is_w, misal, tmo;
  logic [3:0]        req_sel;
  logic [31:0]       req_dat;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       rdata;

  // Request decode and lane steering.
  always_comb begin
    is_b = 1'b0;
    is_h = 1'b0;
    is_t = 1'b0;
    case (I_op)
      BUSOP_READB, BUSOP_READBU, BUSOP_WRITEB: is_b = 1'b1;
      BUSOP_READH, BUSOP_READHU, BUSOP_WRITEH: is_h = 1'b1;
      BUSOP_READT, BUSOP_WRITET:               is_t = 1'b1;
      default: ;
    endcase
    is_w  = !is_b && !is_h && !is_t;
    misal = ALIGN_CHECK &&
            ((is_h && I_addr[0]) || (is_w && (I_addr[1:0] != 2'b00)));
    if (is_b) begin
      req_sel = 4'b0001 << I_addr[1:0];
      req_dat = {4{I_data[7:0]}};
    end else if (is_h) begin
      req_sel = 4'b0011 << {I_addr[1], 1'b0};
      req_dat = {2{I_data[15:0]}};
    end else if (is_t) begin
      req_sel = 4'b0101;
      req_dat = I_data;
    end else begin
      req_sel = 4'b1111;
      req_dat = I_data;
    end
  end

  // Read extraction from the latched op and low address bits.
  always_comb begin
    lane_b = DAT_I[{lo_q, 3'b000} +: 8];
    lane_h = DAT_I[{lo_q[1], 4'b0000} +: 16];
    case (op_q)
      BUSOP_READB:  rdata = {{24{lane_b[7]}}, lane_b};
      BUSOP_READBU: rdata = {24'b0, lane_b};
      BUSOP_READH:  rdata = {{16{lane_h[15]}}, lane_h};
      BUSOP_READHU: rdata = {16'b0, lane_h};
      BUSOP_READT:  rdata = {28'b0, DAT_I[3:0]};
      default:      rdata = DAT_I;
    endcase
  end

  assign cnt_nxt = cnt_q + 1'b1;
  assign tmo     = (TIMEOUT_CYCLES != 0) && (cnt_nxt == CW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    lo_d    = lo_q;
    data_d  = data_q;
    err_d   = err_q;
    cause_d = cause_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    case (state_q)
      S_BUS: begin
        cnt_d = cnt_nxt;
        // ERR_I beats ACK_I beats the watchdog.
        if (ERR_I) begin
          err_d   = 1'b1;
          cause_d = 2'd1;
        end else if (ACK_I) begin
          if (!op_q[3]) data_d = rdata;
        end else if (tmo) begin
          err_d   = 1'b1;
          cause_d = 2'd2;
        end
        if (ERR_I || ACK_I || tmo) begin
          state_d = S_DONE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
        end
      end
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (I_en) begin
          op_d    = I_op;
          lo_d    = I_addr[1:0];
          cnt_d   = '0;
          err_d   = 1'b0;
          cause_d = 2'd0;
          if (misal) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            cause_d = 2'd3;
            data_d  = '0;
          end else begin
            state_d = S_BUS;
            cyc_d   = 1'b1;
            we_d    = I_op[3];
            adr_d   = {I_addr[ADDR_W-1:2], 2'b00};
            sel_d   = req_sel;
            dat_d   = req_dat;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      lo_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cause_q <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cause_q <= cause_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
    end
  end

  assign O_data      = data_q;
  assign O_busy      = (state_q == S_BUS);
  assign O_done      = (state_q == S_DONE);
  assign O_err       = err_q;
  assign O_err_cause = cause_q;
  assign ADR_O       = adr_q;
  assign DAT_O       = dat_q;
  assign SEL_O       = sel_q;
  assign CYC_O       = cyc_q;
  assign STB_O       = cyc_q;
  assign WE_O        = we_q;

endmodule

// File: tb/tb_wb_cpu_bus_master.sv
// Scoreboard bench for wb_cpu_bus_master: directed plan cases plus random
// traffic against a behavioural model, with a slave model and a done monitor.
module tb_wb_cpu_bus_master;

  localparam int T = 4;

  localparam logic [3:0] RB  = 4'h0;
  localparam logic [3:0] RBU = 4'h1;
  localparam logic [3:0] RH  = 4'h2;
  localparam logic [3:0] RHU = 4'h3;
  localparam logic [3:0] RW  = 4'h4;
  localparam logic [3:0] RT  = 4'h5;
  localparam logic [3:0] WB  = 4'h8;
  localparam logic [3:0] WH  = 4'hA;
  localparam logic [3:0] WW  = 4'hC;
  localparam logic [3:0] WT  = 4'hD;

  typedef enum int {K_ACK, K_ERR, K_BOTH, K_SILENT} kind_t;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        we;
    kind_t       kind;
    int          waits;
    logic [31:0] rdat;
    int          len;
    bit          b2b;
  } bus_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [1:0]  cause;
    int          t0;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        RST_I;
  logic        I_en;
  logic [3:0]  I_op;
  logic [31:0] I_addr, I_data;
  logic [31:0] O_data;
  logic        O_busy, O_done, O_err;
  logic [1:0]  O_err_cause;
  logic        ACK_I, ERR_I;
  logic [31:0] DAT_I;
  logic [31:0] ADR_O, DAT_O;
  logic [3:0]  SEL_O;
  logic        CYC_O, STB_O, WE_O;

  bus_t        bq[$];
  exp_t        sq[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  logic [31:0] m_data = 32'h0;
  bit          stray = 1'b0;

  wb_cpu_bus_master #(
    .ADDR_W(32),
    .TIMEOUT_CYCLES(T),
    .ALIGN_CHECK(1'b1)
  ) dut (
    .CLK_I(clk),
    .RST_I(RST_I),
    .I_en(I_en),
    .I_op(I_op),
    .I_addr(I_addr),
    .I_data(I_data),
    .O_data(O_data),
    .O_busy(O_busy),
    .O_done(O_done),
    .O_err(O_err),
    .O_err_cause(O_err_cause),
    .ACK_I(ACK_I),
    .ERR_I(ERR_I),
    .DAT_I(DAT_I),
    .ADR_O(ADR_O),
    .DAT_O(DAT_O),
    .SEL_O(SEL_O),
    .CYC_O(CYC_O),
    .STB_O(STB_O),
    .WE_O(WE_O)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [3:0] op);
    case (op)
      RB, RBU, WB: return 1;
      RH, RHU, WH: return 2;
      RT, WT:      return 0;
      default:     return 4;
    endcase
  endfunction

  function automatic bit is_wr(input logic [3:0] op);
    return (op == WB) || (op == WH) || (op == WW) || (op == WT);
  endfunction

  function automatic bit misaligned(input logic [3:0] op, input logic [31:0] a);
    int sz;
    sz = size_of(op);
    return (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
  endfunction

  function automatic logic [3:0] exp_sel(input logic [3:0] op, input logic [31:0] a);
    case (size_of(op))
      1:       return 4'(1 << (a % 4));
      2:       return 4'(3 << ((a % 4) / 2 * 2));
      0:       return 4'b0101;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_dat(input logic [3:0] op, input logic [31:0] d);
    case (size_of(op))
      1:       return (d % 256) * 32'h01010101;
      2:       return (d % 65536) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * (a % 4))) % 256;
    h = (d >> (16 * ((a % 4) / 2))) % 65536;
    case (op)
      RB:      return (b >= 128) ? b - 256 : b;
      RBU:     return b;
      RH:      return (h >= 32768) ? h - 65536 : h;
      RHU:     return h;
      RT:      return d % 16;
      default: return d;
    endcase
  endfunction

  // Issue a request at the current negedge; ends one negedge later.
  task automatic start(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] d, input kind_t k, input int w,
                       input logic [31:0] rd, input bit b2b, input bit abort);
    bus_t b;
    exp_t e;
    I_en   = 1'b1;
    I_op   = op;
    I_addr = a;
    I_data = d;
    e.t0   = cyc;
    if (misaligned(op, a)) begin
      m_data  = 32'h0;
      e.err   = 1'b1;
      e.cause = 2'd3;
      e.lat   = 1;
    end else begin
      b.adr   = a - (a % 4);
      b.sel   = exp_sel(op, a);
      b.dat   = exp_dat(op, d);
      b.we    = is_wr(op);
      b.kind  = k;
      b.waits = w;
      b.rdat  = rd;
      b.b2b   = b2b;
      b.len   = abort ? 2 : (k == K_SILENT ? T : w + 1);
      bq.push_back(b);
      e.lat = (k == K_SILENT) ? T + 1 : w + 2;
      if (k == K_ACK) begin
        e.err   = 1'b0;
        e.cause = 2'd0;
        if (!is_wr(op)) m_data = exp_read(op, a, rd);
      end else if (k == K_SILENT) begin
        e.err   = 1'b1;
        e.cause = 2'd2;
      end else begin
        e.err   = 1'b1;
        e.cause = 2'd1;
      end
    end
    e.data = m_data;
    if (!abort) sq.push_back(e);
    @(negedge clk);
    I_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((O_busy || O_done || sq.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) fail("wait_idle_timeout");
  endtask

  task automatic wait_done();
    int n = 0;
    while (O_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) fail("wait_done_timeout");
  endtask

  // ---------------- slave model ----------------
  initial begin : slave
    bus_t cur;
    bit   act = 1'b0;
    int   wc = 0;
    int   hi = 0;
    int   lo = 0;
    ACK_I = 1'b0;
    ERR_I = 1'b0;
    DAT_I = 32'h0;
    forever begin
      @(negedge clk);
      ACK_I = 1'b0;
      ERR_I = 1'b0;
      DAT_I = $urandom;
      if (CYC_O === 1'b1) begin
        if (hi == 0) begin
          if (bq.size() == 0) begin
            fail("unexpected_bus_cycle");
          end else begin
            cur = bq.pop_front();
            act = 1'b1;
            wc  = 0;
            if (cur.b2b) check("b2b_cyc_gap", 32'(lo), 32'd1);
            check("busy", 32'(O_busy), 32'd1);
          end
        end
        hi++;
        lo = 0;
        if (act) begin
          check("adr", ADR_O, cur.adr);
          check("sel", 32'(SEL_O), 32'(cur.sel));
          check("we", 32'(WE_O), 32'(cur.we));
          check("stb", 32'(STB_O), 32'd1);
          if (cur.we) check("dat_o", DAT_O, cur.dat);
          if (cur.kind != K_SILENT && wc == cur.waits) begin
            ACK_I = (cur.kind == K_ACK || cur.kind == K_BOTH);
            ERR_I = (cur.kind == K_ERR || cur.kind == K_BOTH);
            DAT_I = cur.rdat;
          end
          wc++;
        end
      end else begin
        if (hi != 0 && act) check("cyc_len", 32'(hi), 32'(cur.len));
        hi  = 0;
        act = 1'b0;
        lo++;
        if (stray) begin
          ACK_I = 1'b1;
          ERR_I = 1'b1;
        end
      end
    end
  end

  // ---------------- completion monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (O_done === 1'b1) begin
        if (sq.size() == 0) begin
          fail("unexpected_done");
        end else begin
          e = sq.pop_front();
          check("O_data", O_data, e.data);
          check("O_err", 32'(O_err), 32'(e.err));
          check("O_err_cause", 32'(O_err_cause), 32'(e.cause));
          check("latency", 32'(cyc - e.t0), 32'(e.lat));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : driver
    logic [3:0] ops[10];
    bit chain;
    bit prev_bus;
    ops = '{RB, RBU, RH, RHU, RW, RT, WB, WH, WW, WT};
    RST_I  = 1'b1;
    I_en   = 1'b0;
    I_op   = 4'h0;
    I_addr = 32'h0;
    I_data = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_O_data", O_data, 32'h0);
    check("rst_O_busy", 32'(O_busy), 32'd0);
    check("rst_O_done", 32'(O_done), 32'd0);
    check("rst_O_err", 32'(O_err), 32'd0);
    check("rst_CYC_O", 32'(CYC_O), 32'd0);
    check("rst_SEL_O", 32'(SEL_O), 32'd0);
    check("rst_ADR_O", ADR_O, 32'h0);
    RST_I = 1'b0;
    @(negedge clk);

    start(RW, 32'h100, 32'h0, K_ACK, 0, 32'hDEADBEEF, 1'b0, 1'b0);
    wait_idle();
    check("readw_data", O_data, 32'hDEADBEEF);

    start(RB, 32'h103, 32'h0, K_ACK, 0, 32'h80AABBCC, 1'b0, 1'b0);
    wait_idle();
    check("readb_data", O_data, 32'hFFFFFF80);
    start(RBU, 32'h103, 32'h0, K_ACK, 1, 32'h80AABBCC, 1'b0, 1'b0);
    wait_idle();
    check("readbu_data", O_data, 32'h00000080);
    start(RHU, 32'h102, 32'h0, K_ACK, 0, 32'h80AABBCC, 1'b0, 1'b0);
    wait_idle();
    check("readhu_data", O_data, 32'h000080AA);

    start(WH, 32'h202, 32'h1234, K_ACK, 2, 32'h0, 1'b0, 1'b0);
    check("wh_adr", ADR_O, 32'h200);
    check("wh_sel", 32'(SEL_O), 32'hC);
    check("wh_dat", DAT_O, 32'h12341234);
    check("wh_we", 32'(WE_O), 32'd1);
    I_en   = 1'b1;
    I_op   = RB;
    I_addr = 32'h55;
    I_data = 32'hFFFFFFFF;
    @(negedge clk);
    I_en = 1'b0;
    wait_idle();

    start(RW, 32'h101, 32'h0, K_ACK, 0, 32'h0, 1'b0, 1'b0);
    check("mis_cyc", 32'(CYC_O), 32'd0);
    check("mis_done", 32'(O_done), 32'd1);
    check("mis_cause", 32'(O_err_cause), 32'd3);
    wait_idle();

    start(RW, 32'h110, 32'h0, K_SILENT, 0, 32'h0, 1'b0, 1'b0);
    wait_idle();
    check("tmo_cause", 32'(O_err_cause), 32'd2);
    start(RW, 32'h114, 32'h0, K_BOTH, 3, 32'h0, 1'b0, 1'b0);
    wait_idle();
    check("both_cause", 32'(O_err_cause), 32'd1);
    start(RH, 32'h116, 32'h0, K_ACK, 3, 32'h0000F00D, 1'b0, 1'b0);
    wait_idle();

    stray = 1'b1;
    repeat (3) @(negedge clk);
    stray = 1'b0;
    check("stray_idle_busy", 32'(O_busy), 32'd0);

    start(RW, 32'h300, 32'h0, K_SILENT, 0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    RST_I = 1'b1;
    @(negedge clk);
    RST_I  = 1'b0;
    m_data = 32'h0;
    check("rstbus_cyc", 32'(CYC_O), 32'd0);
    check("rstbus_stb", 32'(STB_O), 32'd0);
    check("rstbus_we", 32'(WE_O), 32'd0);
    check("rstbus_data", O_data, 32'h0);
    check("rstbus_busy", 32'(O_busy), 32'd0);
    wait_idle();

    start(RW, 32'h400, 32'h0, K_ACK, 1, 32'hCAFEF00D, 1'b0, 1'b0);
    wait_done();
    start(WW, 32'h404, 32'h01234567, K_ACK, 0, 32'h0, 1'b1, 1'b0);
    wait_idle();

    chain    = 1'b0;
    prev_bus = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      kind_t       k;
      int          r;
      bit          mis;
      op = ops[$urandom_range(9)];
      a  = $urandom;
      if ($urandom_range(1) == 0) a = a - (a % 4);
      r = $urandom_range(99);
      k = (r < 70) ? K_ACK : (r < 80) ? K_ERR : (r < 85) ? K_BOTH : K_SILENT;
      mis = misaligned(op, a);
      start(op, a, $urandom, k, $urandom_range(T - 1), $urandom,
            chain && prev_bus && !mis, 1'b0);
      prev_bus = !mis;
      chain    = ($urandom_range(3) == 0);
      if (chain) wait_done();
      else wait_idle();
    end
    wait_idle();
    check("sb_empty", 32'(sq.size()), 32'd0);
    check("bus_q_empty", 32'(bq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
